// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, FSM states and request payload for the data-memory access unit.
package mem_access_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            sgn;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    // Illegal size, or a halfword/word not aligned to its own size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Big-endian lane extraction for loads and lane merge for sub-word stores.
module byte_lane_unit
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] rword_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] merge_base_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] merge_data_o
);

    logic [4:0]      byte_sh;
    logic [4:0]      half_sh;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_data;

    // Offset 00 sits in the top byte, so shift = (3 - offset) * 8.
    assign byte_sh = {~addr_lo_i, 3'b000};
    assign half_sh = {~addr_lo_i[1], 4'b0000};
    assign byte_v  = 8'(rword_i >> byte_sh);
    assign half_v  = 16'(rword_i >> half_sh);

    always_comb begin
        load_data_o = rword_i;
        lane_mask   = '1;
        lane_data   = wdata_i;
        unique case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{signed_i & byte_v[7]}}, byte_v};
                lane_mask   = XLEN'(32'h0000_00FF) << byte_sh;
                lane_data   = XLEN'({24'd0, wdata_i[7:0]}) << byte_sh;
            end
            SZ_HALF: begin
                load_data_o = {{16{signed_i & half_v[15]}}, half_v};
                lane_mask   = XLEN'(32'h0000_FFFF) << half_sh;
                lane_data   = XLEN'({16'd0, wdata_i[15:0]}) << half_sh;
            end
            default: ;
        endcase
    end

    assign merge_data_o = (merge_base_i & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-cycle data memory, with optional RMW sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit RMW_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic            req_we_in,
    input  logic [1:0]      req_size_in,
    input  logic            req_signed_in,
    input  logic [XLEN-1:0] req_addr_in,
    input  logic [XLEN-1:0] req_wdata_in,
    output logic            resp_valid_out,
    output logic [XLEN-1:0] resp_rdata_out,
    output logic            resp_err_out,
    output logic [XLEN-1:0] mem_addr_out,
    output logic [XLEN-1:0] mem_writedata_out,
    output logic            mem_re_out,
    output logic            mem_we_out,
    output logic [1:0]      mem_size_out,
    input  logic [XLEN-1:0] mem_readdata_in
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            mem_re_d, mem_we_d;
    logic [XLEN-1:0] mem_addr_d, mem_wdata_d;
    logic [1:0]      mem_size_d;
    logic            resp_valid_d, resp_err_d;
    logic [XLEN-1:0] resp_rdata_d;

    logic            bad_c;
    logic            rmw_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] merge_data_c;

    assign bad_c         = req_bad(req_size_in, req_addr_in[1:0]);
    assign rmw_c         = RMW_EN && (req_d.size != SZ_WORD);
    assign req_ready_out = (state_q == ST_IDLE) && !reset;

    // Next state and request capture.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    req_d = '{we: req_we_in, size: req_size_in, sgn: req_signed_in,
                              addr: req_addr_in, wdata: req_wdata_in};
                    err_d = bad_c;
                    if (bad_c)                                    state_d = ST_RESP;
                    else if (!req_we_in)                          state_d = ST_RD;
                    else if ((req_size_in == SZ_WORD) || !RMW_EN) state_d = ST_WR;
                    else                                          state_d = ST_RD;
                end
            end
            ST_RD: begin
                rdata_d = mem_readdata_in;
                state_d = req_q.we ? ST_WR : ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    byte_lane_unit u_lanes (
        .addr_lo_i    (req_d.addr[1:0]),
        .size_i       (req_d.size),
        .signed_i     (req_d.sgn),
        .rword_i      (rdata_d),
        .wdata_i      (req_d.wdata),
        .merge_base_i (rmw_c ? rdata_d : '0),
        .load_data_o  (load_data_c),
        .merge_data_o (merge_data_c)
    );

    // Outputs are decoded from the next state so they register cleanly.
    always_comb begin
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_size_d   = SZ_WORD;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        unique case (state_d)
            ST_RD: begin
                mem_re_d   = 1'b1;
                mem_addr_d = {req_d.addr[XLEN-1:2], 2'b00};
            end
            ST_WR: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = merge_data_c;
                if ((req_d.size == SZ_WORD) || RMW_EN) begin
                    mem_addr_d = {req_d.addr[XLEN-1:2], 2'b00};
                end else begin
                    mem_addr_d = req_d.addr;
                    mem_size_d = req_d.size;
                end
            end
            ST_RESP: begin
                resp_valid_d = 1'b1;
                resp_err_d   = err_d;
                if (!err_d && !req_d.we) resp_rdata_d = load_data_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            req_q             <= '0;
            rdata_q           <= '0;
            err_q             <= 1'b0;
            mem_re_out        <= 1'b0;
            mem_we_out        <= 1'b0;
            mem_addr_out      <= '0;
            mem_writedata_out <= '0;
            mem_size_out      <= SZ_WORD;
            resp_valid_out    <= 1'b0;
            resp_err_out      <= 1'b0;
            resp_rdata_out    <= '0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            rdata_q           <= rdata_d;
            err_q             <= err_d;
            mem_re_out        <= mem_re_d;
            mem_we_out        <= mem_we_d;
            mem_addr_out      <= mem_addr_d;
            mem_writedata_out <= mem_wdata_d;
            mem_size_out      <= mem_size_d;
            resp_valid_out    <= resp_valid_d;
            resp_err_out      <= resp_err_d;
            resp_rdata_out    <= resp_rdata_d;
        end
    end

endmodule
